// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
//
// Handshake: the master raises imem_req_o with imem_addr_o and holds both
// stable until the rising edge at which the slave returns imem_ack_i=1;
// imem_rdata_i is valid only in that ack cycle. Ack may arrive in the
// same cycle as the request. At most one request is outstanding. The master
// may drop req only on reset, so the slave must tolerate an abandoned request.
interface if_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one-outstanding reads
// to instruction memory, drives the IF/ID registers, absorbs stalls with a
// one-entry hold buffer and applies redirects, dropping wrong-path fetches.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  if_stage_if.master         imem,
  output logic [31:0]        pc_o,
  output logic [31:0]        inst_o,
  output logic               valid_o,
  output logic               stallreq_o,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] req_pc, req_pc_n;
  logic [31:0] pend_pc, pend_pc_n;
  logic [31:0] hold_inst, hold_inst_n;
  logic [31:0] hold_pc, hold_pc_n;
  logic        hold_valid, hold_valid_n;
  logic [31:0] pc_n, inst_n;
  logic        valid_n;
  logic [31:0] target;

  assign target           = {redirect_pc_i[31:2], 2'b00};
  assign imem.imem_req_o  = (state == S_REQ) | (state == S_DROP);
  assign imem.imem_addr_o = req_pc;
  assign stallreq_o       = ((state == S_REQ) & ~imem.imem_ack_i) | (state == S_DROP);
  assign dbg_state        = state;

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      req_pc     <= RESET_PC;
      pend_pc    <= 32'h0;
      hold_inst  <= 32'h0;
      hold_pc    <= 32'h0;
      hold_valid <= 1'b0;
      pc_o       <= 32'h0;
      inst_o     <= 32'h0;
      valid_o    <= 1'b0;
    end else begin
      state      <= state_n;
      req_pc     <= req_pc_n;
      pend_pc    <= pend_pc_n;
      hold_inst  <= hold_inst_n;
      hold_pc    <= hold_pc_n;
      hold_valid <= hold_valid_n;
      pc_o       <= pc_n;
      inst_o     <= inst_n;
      valid_o    <= valid_n;
    end
  end

  // Next-state and next-register logic; redirect outranks stall and ack.
  always_comb begin
    state_n      = state;
    req_pc_n     = req_pc;
    pend_pc_n    = pend_pc;
    hold_inst_n  = hold_inst;
    hold_pc_n    = hold_pc;
    hold_valid_n = hold_valid;
    pc_n         = pc_o;
    inst_n       = inst_o;
    valid_n      = valid_o;

    if (redirect_i) begin
      valid_n      = 1'b0;
      inst_n       = 32'h0;
      hold_valid_n = 1'b0;
      case (state)
        S_REQ: begin
          if (imem.imem_ack_i) begin
            req_pc_n = target;
          end else begin
            pend_pc_n = target;
            state_n   = S_DROP;
          end
        end
        S_DROP:  pend_pc_n = target;
        default: begin
          req_pc_n = target;
          state_n  = S_REQ;
        end
      endcase
    end else begin
      case (state)
        S_IDLE: state_n = S_REQ;
        S_REQ: begin
          if (imem.imem_ack_i) begin
            req_pc_n = req_pc + 32'd4;
            if (stall_i) begin
              hold_pc_n    = req_pc;
              hold_inst_n  = imem.imem_rdata_i;
              hold_valid_n = 1'b1;
              state_n      = S_HOLD;
            end else begin
              pc_n    = req_pc;
              inst_n  = imem.imem_rdata_i;
              valid_n = 1'b1;
            end
          end else if (!stall_i) begin
            valid_n = 1'b0;
            inst_n  = 32'h0;
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            pc_n         = hold_pc;
            inst_n       = hold_inst;
            valid_n      = 1'b1;
            hold_valid_n = 1'b0;
            state_n      = S_REQ;
          end
        end
        S_DROP: begin
          if (!stall_i) begin
            valid_n = 1'b0;
            inst_n  = 32'h0;
          end
          if (imem.imem_ack_i) begin
            req_pc_n = pend_pc;
            state_n  = S_REQ;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: per-cycle vector table plus short
// hand-written sequences for hold/redirect/drop and asynchronous reset.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        stallreq_o;
  logic [1:0]  dbg_state;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (bus.master),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .valid_o       (valid_o),
    .stallreq_o    (stallreq_o),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        sreq;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(logic stall, logic redir, logic [31:0] rpc, logic ack,
                              logic req, logic [31:0] addr, logic sreq, logic valid,
                              logic [31:0] pc, logic [31:0] inst);
    vec_t v;
    v.stall = stall; v.redir = redir; v.rpc = rpc; v.ack = ack;
    v.req = req; v.addr = addr; v.sreq = sreq; v.valid = valid;
    v.pc = pc; v.inst = inst;
    return v;
  endfunction

  // Memory contents: upper half a tag, lower half the address.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: called at a falling edge; drives one cycle, checks, moves on.
  task automatic run_vec(input vec_t v, input string tag);
    stall_i          = v.stall;
    redirect_i       = v.redir;
    redirect_pc_i    = v.rpc;
    bus.imem_ack_i   = v.ack;
    bus.imem_rdata_i = v.ack ? mem_word(bus.imem_addr_o) : 32'hDEAD_BEEF;
    #1;
    check({tag, " req"},      {31'h0, bus.imem_req_o}, {31'h0, v.req});
    check({tag, " addr"},     bus.imem_addr_o,         v.addr);
    check({tag, " stallreq"}, {31'h0, stallreq_o},     {31'h0, v.sreq});
    check({tag, " valid"},    {31'h0, valid_o},        {31'h0, v.valid});
    check({tag, " pc"},       pc_o,                    v.pc);
    check({tag, " inst"},     inst_o,                  v.inst);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    bus.imem_ack_i = 1'b0;
    bus.imem_rdata_i = 32'h0;

    //            stall redir rpc            ack  req addr           sreq v  pc             inst
    vecs[0]  = mk(0, 0, 32'h0,          0,   0, 32'h0000_0000, 0, 0, 32'h0000_0000, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,          1,   1, 32'h0000_0000, 0, 0, 32'h0000_0000, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0,          1,   1, 32'h0000_0004, 0, 1, 32'h0000_0000, 32'hC0DE_0000);
    vecs[3]  = mk(0, 0, 32'h0,          1,   1, 32'h0000_0008, 0, 1, 32'h0000_0004, 32'hC0DE_0004);
    // three-cycle ack latency
    vecs[4]  = mk(0, 0, 32'h0,          0,   1, 32'h0000_000C, 1, 1, 32'h0000_0008, 32'hC0DE_0008);
    vecs[5]  = mk(0, 0, 32'h0,          0,   1, 32'h0000_000C, 1, 0, 32'h0000_0008, 32'h0);
    vecs[6]  = mk(0, 0, 32'h0,          1,   1, 32'h0000_000C, 0, 0, 32'h0000_0008, 32'h0);
    vecs[7]  = mk(0, 0, 32'h0,          0,   1, 32'h0000_0010, 1, 1, 32'h0000_000C, 32'hC0DE_000C);
    vecs[8]  = mk(0, 0, 32'h0,          0,   1, 32'h0000_0010, 1, 0, 32'h0000_000C, 32'h0);
    vecs[9]  = mk(0, 0, 32'h0,          1,   1, 32'h0000_0010, 0, 0, 32'h0000_000C, 32'h0);
    // four-cycle stall during continuous fetch
    vecs[10] = mk(1, 0, 32'h0,          1,   1, 32'h0000_0014, 0, 1, 32'h0000_0010, 32'hC0DE_0010);
    vecs[11] = mk(1, 0, 32'h0,          0,   0, 32'h0000_0018, 0, 1, 32'h0000_0010, 32'hC0DE_0010);
    vecs[12] = mk(1, 0, 32'h0,          0,   0, 32'h0000_0018, 0, 1, 32'h0000_0010, 32'hC0DE_0010);
    vecs[13] = mk(1, 0, 32'h0,          0,   0, 32'h0000_0018, 0, 1, 32'h0000_0010, 32'hC0DE_0010);
    vecs[14] = mk(0, 0, 32'h0,          0,   0, 32'h0000_0018, 0, 1, 32'h0000_0010, 32'hC0DE_0010);
    vecs[15] = mk(0, 0, 32'h0,          1,   1, 32'h0000_0018, 0, 1, 32'h0000_0014, 32'hC0DE_0014);
    // redirect meeting an ack, unaligned target
    vecs[16] = mk(0, 1, 32'h0000_0103,  1,   1, 32'h0000_001C, 0, 1, 32'h0000_0018, 32'hC0DE_0018);
    vecs[17] = mk(0, 0, 32'h0,          1,   1, 32'h0000_0100, 0, 0, 32'h0000_0018, 32'h0);
    vecs[18] = mk(0, 0, 32'h0,          1,   1, 32'h0000_0104, 0, 1, 32'h0000_0100, 32'hC0DE_0100);
    // redirect with no ack, ack two cycles later
    vecs[19] = mk(0, 1, 32'h0000_0200,  0,   1, 32'h0000_0108, 1, 1, 32'h0000_0104, 32'hC0DE_0104);
    vecs[20] = mk(0, 0, 32'h0,          0,   1, 32'h0000_0108, 1, 0, 32'h0000_0104, 32'h0);
    vecs[21] = mk(0, 0, 32'h0,          1,   1, 32'h0000_0108, 1, 0, 32'h0000_0104, 32'h0);
    vecs[22] = mk(0, 0, 32'h0,          1,   1, 32'h0000_0200, 0, 0, 32'h0000_0104, 32'h0);
    // redirect to the top word, then wrap to 0
    vecs[23] = mk(0, 1, 32'hFFFF_FFFE,  1,   1, 32'h0000_0204, 0, 1, 32'h0000_0200, 32'hC0DE_0200);
    vecs[24] = mk(0, 0, 32'h0,          1,   1, 32'hFFFF_FFFC, 0, 0, 32'h0000_0200, 32'h0);
    vecs[25] = mk(0, 0, 32'h0,          0,   1, 32'h0000_0000, 1, 1, 32'hFFFF_FFFC, 32'hC0DE_FFFC);

    repeat (2) @(negedge clk);
    check("reset req",      {31'h0, bus.imem_req_o}, 32'h0);
    check("reset stallreq", {31'h0, stallreq_o},     32'h0);
    check("reset valid",    {31'h0, valid_o},        32'h0);
    check("reset state",    {30'h0, dbg_state},      32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stall captures a word, then a redirect while stalled discards it.
    run_vec(mk(1, 0, 32'h0,         1, 1, 32'h0000_0000, 0, 0, 32'hFFFF_FFFC, 32'h0), "holdA1");
    check("holdA1 state", {30'h0, dbg_state}, 32'h2);
    run_vec(mk(1, 1, 32'h0000_0041, 0, 0, 32'h0000_0004, 0, 0, 32'hFFFF_FFFC, 32'h0), "holdA2");
    run_vec(mk(0, 0, 32'h0,         1, 1, 32'h0000_0040, 0, 0, 32'hFFFF_FFFC, 32'h0), "holdA3");
    // Redirect with no ack, retargeted again while dropping.
    run_vec(mk(0, 1, 32'h0000_0080, 0, 1, 32'h0000_0044, 1, 1, 32'h0000_0040, 32'hC0DE_0040), "dropB1");
    check("dropB1 state", {30'h0, dbg_state}, 32'h3);
    run_vec(mk(0, 1, 32'h0000_00C0, 0, 1, 32'h0000_0044, 1, 0, 32'h0000_0040, 32'h0), "dropB2");
    run_vec(mk(0, 0, 32'h0,         1, 1, 32'h0000_0044, 1, 0, 32'h0000_0040, 32'h0), "dropB3");
    run_vec(mk(0, 0, 32'h0,         0, 1, 32'h0000_00C0, 1, 0, 32'h0000_0040, 32'h0), "dropB4");

    // Asynchronous reset mid-request, between clock edges.
    #2 rst = 1'b1;
    #1;
    check("async req",      {31'h0, bus.imem_req_o}, 32'h0);
    check("async addr",     bus.imem_addr_o,         32'h0);
    check("async stallreq", {31'h0, stallreq_o},     32'h0);
    check("async pc",       pc_o,                    32'h0);
    check("async state",    {30'h0, dbg_state},      32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0), "rst_idle");
    run_vec(mk(0, 0, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0, 32'h0), "rst_req");
    run_vec(mk(0, 0, 32'h0, 0, 1, 32'h4, 1, 1, 32'h0, 32'hC0DE_0000), "rst_first");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
